// File: rtl/v_pkg.sv
// Shared types for the v list engine and its update/lookup scheduler.
package v_pkg;

  localparam int ID_W   = 8;
  localparam int CMD_W  = 2;
  localparam int KEY_W  = 16;
  localparam int SIZE_W = 12;
  localparam int LVL_W  = 4;

  localparam int N_REQ_DFLT   = 4;
  localparam int UPD_LAT_DFLT = 3;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [LVL_W-1:0]  level_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 2'd0,
    CMD_INS = 2'd1,
    CMD_DEL = 2'd2,
    CMD_MOD = 2'd3
  } cmd_t;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_req_t;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/v_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr, and the pointer
// that follows it. With nothing valid, gnt is zero and nxt_ptr equals ptr.
module v_rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vld,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr
);

  int k;

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt     = '0;
    nxt_ptr = ptr;
    k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (vld[k[PW-1:0]]) begin
        gnt             = '0;
        gnt[k[PW-1:0]]  = 1'b1;
        nxt_ptr         = (k == N - 1) ? '0 : PW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/v_upd_sched.sv
// Round-robin update scheduler plus hazard-gated lookup forwarder in front of v.
// Define V_UPD_SCHED_HAZARD_EN to build the in-flight window that stalls conflicting lookups.
module v_upd_sched
  import v_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DFLT,
  parameter int UPD_LAT = UPD_LAT_DFLT
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [N_REQ-1:0]          i_req_vld,
  input  logic [N_REQ*ID_W-1:0]     i_req_prod_id,
  input  logic [N_REQ*CMD_W-1:0]    i_req_cmd,
  input  logic [N_REQ*KEY_W-1:0]    i_req_key,
  input  logic [N_REQ*SIZE_W-1:0]   i_req_size,
  output logic [N_REQ-1:0]          o_req_rdy,
  input  logic                      i_q_vld,
  input  logic [ID_W-1:0]           i_q_prod_id,
  input  logic [LVL_W-1:0]          i_q_level,
  output logic                      o_q_rdy,
  output logic                      o_upd_vld,
  output logic [ID_W-1:0]           o_upd_prod_id,
  output logic [CMD_W-1:0]          o_upd_cmd,
  output logic [KEY_W-1:0]          o_upd_key,
  output logic [SIZE_W-1:0]         o_upd_size,
  output logic                      o_lut_vld,
  output logic [ID_W-1:0]           o_lut_prod_id,
  output logic [LVL_W-1:0]          o_lut_level
);

  localparam int PW = ptr_w(N_REQ);

  if (N_REQ < 2 || UPD_LAT < 1) begin : g_bad_cfg
    $error("v_upd_sched: N_REQ must be >= 2 and UPD_LAT >= 1");
  end

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    nxt_ptr;
  logic [N_REQ-1:0] gnt;
  logic             any_gnt;
  upd_req_t         req_sel;
  logic             q_acc;

  v_rr_arb #(.N(N_REQ), .PW(PW)) u_arb (
    .vld     (i_req_vld),
    .ptr     (ptr),
    .gnt     (gnt),
    .nxt_ptr (nxt_ptr)
  );

  assign any_gnt   = |gnt;
  assign o_req_rdy = gnt & {N_REQ{arst_n}};

  always_comb begin
    req_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        req_sel.prod_id = i_req_prod_id[k*ID_W +: ID_W];
        req_sel.cmd     = cmd_t'(i_req_cmd[k*CMD_W +: CMD_W]);
        req_sel.key     = i_req_key[k*KEY_W +: KEY_W];
        req_sel.size    = i_req_size[k*SIZE_W +: SIZE_W];
      end
    end
  end

`ifdef V_UPD_SCHED_HAZARD_EN
  logic [UPD_LAT-1:0] win_vld;
  id_t                win_id [UPD_LAT];
  logic               hit;

  // Stage 0 mirrors the update being presented to v; older stages track it until visible.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      win_vld <= '0;
      for (int i = 0; i < UPD_LAT; i++) win_id[i] <= '0;
    end else begin
      win_vld[0] <= any_gnt;
      win_id[0]  <= req_sel.prod_id;
      for (int i = 1; i < UPD_LAT; i++) begin
        win_vld[i] <= win_vld[i-1];
        win_id[i]  <= win_id[i-1];
      end
    end
  end

  always_comb begin
    hit = any_gnt && (req_sel.prod_id == i_q_prod_id);
    for (int i = 0; i < UPD_LAT; i++) begin
      if (win_vld[i] && (win_id[i] == i_q_prod_id)) hit = 1'b1;
    end
  end

  assign q_acc = i_q_vld & ~hit;
`else
  assign q_acc = i_q_vld;
`endif

  assign o_q_rdy = q_acc & arst_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr           <= '0;
      o_upd_vld     <= 1'b0;
      o_upd_prod_id <= '0;
      o_upd_cmd     <= '0;
      o_upd_key     <= '0;
      o_upd_size    <= '0;
      o_lut_vld     <= 1'b0;
      o_lut_prod_id <= '0;
      o_lut_level   <= '0;
    end else begin
      o_upd_vld <= any_gnt;
      if (any_gnt) begin
        ptr           <= nxt_ptr;
        o_upd_prod_id <= req_sel.prod_id;
        o_upd_cmd     <= req_sel.cmd;
        o_upd_key     <= req_sel.key;
        o_upd_size    <= req_sel.size;
      end
      o_lut_vld <= q_acc;
      if (q_acc) begin
        o_lut_prod_id <= i_q_prod_id;
        o_lut_level   <= i_q_level;
      end
    end
  end

endmodule
